// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: runs a programmed list of Knight commands through
// RemoteComm_e one at a time, checking each acknowledge byte.
module tour_cmd_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TMO_CLKS = 1000000,
  parameter logic [7:0]  ACK_VAL  = 8'hA5,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned TW = $clog2(TMO_CLKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   num_cmds,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   cmd,
  output logic          send_cmd,
  input  logic          cmd_sent,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] cmd_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_NEXT,
    S_FAIL
  } state_e;

  localparam logic [1:0] E_NAK = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;
  localparam logic [1:0] E_UNX = 2'd3;

  state_e state_q, state_d;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];

  logic [15:0]   cmd_q, cmd_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [1:0]    fail_code;
  logic          is_ack;
  logic          tmo_hit;
  logic          last;
  logic          in_idle;
  logic          start_go;
  logic          wr_go;
  logic          waiting;

  assign in_idle  = (state_q == S_IDLE);
  assign is_ack   = (resp == ACK_VAL);
  assign tmo_hit  = (tmr_q >= TW'(TMO_CLKS - 1));
  assign last     = ({1'b0, idx_q} == (cnt_q - (AW+1)'(1)));
  assign start_go = in_idle && start && !abort;
  assign wr_go    = in_idle && wr_en;
  assign waiting  = (state_q == S_WAIT_SENT) ||
                    (state_q == S_WAIT_RESP);

  // Slot memory write path; writes only land while idle.
  always_comb begin
    mem_d = mem_q;
    if (wr_go) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Slot storage; contents survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an event on the timeout cycle beats the timeout.
  always_comb begin
    state_d   = state_q;
    fail_code = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (start_go && (num_cmds != '0)) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        unique case (1'b1)
          (resp_rdy && cmd_sent && is_ack): begin
            state_d = S_NEXT;
          end
          (resp_rdy && cmd_sent && !is_ack): begin
            state_d   = S_FAIL;
            fail_code = E_NAK;
          end
          (resp_rdy && !cmd_sent): begin
            state_d   = S_FAIL;
            fail_code = E_UNX;
          end
          (!resp_rdy && cmd_sent): begin
            state_d = S_WAIT_RESP;
          end
          default: begin
            if (tmo_hit) begin
              state_d   = S_FAIL;
              fail_code = E_TMO;
            end
          end
        endcase
      end
      S_WAIT_RESP: begin
        unique case (1'b1)
          (resp_rdy && is_ack): begin
            state_d = S_NEXT;
          end
          (resp_rdy && !is_ack): begin
            state_d   = S_FAIL;
            fail_code = E_NAK;
          end
          default: begin
            if (tmo_hit) begin
              state_d   = S_FAIL;
              fail_code = E_TMO;
            end
          end
        endcase
      end
      S_NEXT: begin
        state_d = last ? S_IDLE : S_ISSUE;
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && !in_idle) begin
      state_d   = S_IDLE;
      fail_code = 2'd0;
    end
  end

  // Datapath next values: count, index, timer, command word, status.
  always_comb begin
    cmd_d  = cmd_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tmr_d  = tmr_q;
    err_d  = err_q;
    code_d = code_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    if (start_go) begin
      cnt_d  = num_cmds;
      idx_d  = '0;
      err_d  = 1'b0;
      code_d = 2'd0;
      done_d = (num_cmds == '0);
    end
    if (state_q == S_ISSUE) begin
      tmr_d = '0;
    end
    if (waiting && (tmr_q != '1)) begin
      tmr_d = tmr_q + TW'(1);
    end
    if ((state_q == S_NEXT) && (state_d == S_ISSUE)) begin
      idx_d = idx_q + AW'(1);
    end
    if ((state_q == S_NEXT) && (state_d == S_IDLE) && !abort) begin
      done_d = 1'b1;
    end
    // mem_d carries a same-cycle write, so start sees fresh data
    if (state_d == S_ISSUE) begin
      cmd_d = mem_d[idx_d];
    end
    if ((state_d == S_IDLE) && !in_idle) begin
      cmd_d = '0;
    end
    if (state_d == S_FAIL) begin
      err_d  = 1'b1;
      code_d = fail_code;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= 2'd0;
    end else begin
      cmd_q  <= cmd_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  // FSM outputs; send strobe lives exactly in the ISSUE cycle.
  always_comb begin
    send_cmd = (state_q == S_ISSUE);
    cmd      = cmd_q;
    busy     = busy_q;
    done     = done_q;
    err      = err_q;
    err_code = code_q;
    cmd_idx  = idx_q;
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb_tour_cmd_sequencer: directed runs against a behavioural RemoteComm,
// expected events queued by stimulus and checked by a monitor.
module tb_tour_cmd_sequencer;

  localparam int TMO = 100;

  localparam int K_SEND = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  localparam int P_STATE = 0;
  localparam int P_HANG  = 1;
  localparam int P_EMPTY = 2;

  localparam int M_NORMAL = 0;
  localparam int M_NORESP = 1;
  localparam int M_EARLY  = 2;
  localparam int M_SAME   = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          dt;
    string       name;
  } exp_t;

  typedef struct {
    int         kind;
    logic       busy;
    logic       err;
    logic [1:0] code;
    logic [2:0] idx;
    logic       chk_cmd;
    string      name;
  } prb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  num_cmds;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  cmd_idx;

  exp_t q[$];
  prb_t pq[$];
  prb_t mp;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   ack_cyc   = 0;
  int   start_cyc = 0;
  int   send_edge = 0;
  int   rmode     = 0;
  logic err_prev  = 1'b0;
  logic [7:0] rsp_tbl [8];

  tour_cmd_sequencer #(
    .DEPTH    (8),
    .TMO_CLKS (TMO),
    .ACK_VAL  (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .num_cmds (num_cmds),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cmd_idx  (cmd_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  function automatic void ev(input int kind,
                             input logic [31:0] data,
                             input int lat);
    exp_t  e;
    string kn;
    kn = (kind == K_SEND) ? "send" :
         (kind == K_DONE) ? "done" : "err";
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event (data %0h), required none",
               kn, data);
      return;
    end
    e = q.pop_front();
    chk({e.name, "_kind"}, 32'(kind), 32'(e.kind));
    if (kind == e.kind) begin
      chk({e.name, "_data"}, data, e.data);
      if (e.dt != 0) begin
        chk({e.name, "_clks"}, 32'(lat), 32'(e.dt));
      end
    end
  endfunction

  // Monitor: every DUT event pops and checks one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (send_cmd) begin
        ev(K_SEND, 32'(cmd), cyc - ack_cyc);
        // edge that registers the strobe
        send_edge = cyc + 1;
      end
      if (done) begin
        ev(K_DONE, 32'd0, cyc - start_cyc);
      end
      if (err && !err_prev) begin
        ev(K_ERR, {26'd0, err_code, 1'b0, cmd_idx}, cyc - send_edge);
      end
    end
    err_prev = err;
    while (pq.size() > 0) begin
      mp = pq.pop_front();
      if (mp.kind == P_HANG) begin
        checks++;
        errors++;
        $display("FAIL %s: still busy or events pending, required idle",
                 mp.name);
      end else if (mp.kind == P_EMPTY) begin
        chk({mp.name, "_pending"}, 32'(q.size()), 32'd0);
      end else begin
        chk({mp.name, "_busy"}, 32'(busy), 32'(mp.busy));
        chk({mp.name, "_send"}, 32'(send_cmd), 32'd0);
        chk({mp.name, "_err"}, 32'(err), 32'(mp.err));
        chk({mp.name, "_code"}, 32'(err_code), 32'(mp.code));
        chk({mp.name, "_idx"}, 32'(cmd_idx), 32'(mp.idx));
        if (mp.chk_cmd) begin
          chk({mp.name, "_cmd"}, 32'(cmd), 32'd0);
          chk({mp.name, "_done"}, 32'(done), 32'd0);
        end
      end
    end
  end

  // Behavioural RemoteComm_e.
  initial begin
    logic [7:0] r;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (send_cmd && !rst) begin
        r = rsp_tbl[cmd_idx];
        repeat (2) @(negedge clk);
        case (rmode)
          M_NORMAL: begin
            cmd_sent = 1'b1;
            @(negedge clk);
            cmd_sent = 1'b0;
            @(negedge clk);
            resp_rdy = 1'b1;
            resp     = r;
            ack_cyc  = cyc;
            @(negedge clk);
            resp_rdy = 1'b0;
          end
          M_SAME: begin
            cmd_sent = 1'b1;
            resp_rdy = 1'b1;
            resp     = r;
            ack_cyc  = cyc;
            @(negedge clk);
            cmd_sent = 1'b0;
            resp_rdy = 1'b0;
          end
          M_EARLY: begin
            resp_rdy = 1'b1;
            resp     = r;
            @(negedge clk);
            resp_rdy = 1'b0;
          end
          default: begin
            cmd_sent = 1'b1;
            @(negedge clk);
            cmd_sent = 1'b0;
          end
        endcase
      end
    end
  end

  function automatic void push_send(input string nm,
                                    input logic [15:0] d,
                                    input int dt);
    exp_t e;
    e.kind = K_SEND; e.data = 32'(d); e.dt = dt; e.name = nm;
    q.push_back(e);
  endfunction

  function automatic void push_done(input string nm, input int dt);
    exp_t e;
    e.kind = K_DONE; e.data = 32'd0; e.dt = dt; e.name = nm;
    q.push_back(e);
  endfunction

  function automatic void push_err(input string nm,
                                   input logic [1:0] c,
                                   input logic [2:0] i,
                                   input int dt);
    exp_t e;
    e.kind = K_ERR; e.data = {26'd0, c, 1'b0, i};
    e.dt = dt; e.name = nm;
    q.push_back(e);
  endfunction

  task automatic probe(input string nm, input logic b, input logic e,
                       input logic [1:0] c, input logic [2:0] i,
                       input logic cc);
    prb_t p;
    @(posedge clk);
    #1;
    p.kind = P_STATE; p.busy = b; p.err = e; p.code = c;
    p.idx = i; p.chk_cmd = cc; p.name = nm;
    pq.push_back(p);
  endtask

  task automatic push_probe(input string nm, input int k);
    prb_t p;
    p.kind = k; p.busy = 1'b0; p.err = 1'b0; p.code = 2'd0;
    p.idx = 3'd0; p.chk_cmd = 1'b0; p.name = nm;
    pq.push_back(p);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    start = 1'b1; num_cmds = 4'(n); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) push_probe(nm, P_HANG);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by 200us, required self-finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    num_cmds = '0; start = 1'b0; abort = 1'b0; rmode = M_NORMAL;
    for (int i = 0; i < 8; i++) rsp_tbl[i] = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    probe("reset", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);

    wr(0, 16'h2000);
    wr(1, 16'h4004);
    push_send("t1_s0", 16'h2000, 0);
    push_send("t1_s1", 16'h4004, 2);
    push_done("t1_done", 0);
    run(2);
    wait_idle("t1", 100);
    probe("t1_end", 1'b0, 1'b0, 2'd0, 3'd1, 1'b0);

    rsp_tbl[1] = 8'h5A;
    push_send("t2_s0", 16'h2000, 0);
    push_send("t2_s1", 16'h4004, 2);
    push_err("t2_nak", 2'd1, 3'd1, 0);
    run(2);
    wait_idle("t2", 100);
    probe("t2_end", 1'b0, 1'b1, 2'd1, 3'd1, 1'b0);
    rsp_tbl[1] = 8'hA5;

    rmode = M_NORESP;
    push_send("t3_s0", 16'h2000, 0);
    push_err("t3_tmo", 2'd2, 3'd0, TMO);
    run(1);
    wait_idle("t3", 300);
    probe("t3_end", 1'b0, 1'b1, 2'd2, 3'd0, 1'b0);

    rmode = M_EARLY;
    push_send("t4_s0", 16'h2000, 0);
    push_err("t4_unx", 2'd3, 3'd0, 0);
    run(1);
    wait_idle("t4", 100);
    probe("t4_end", 1'b0, 1'b1, 2'd3, 3'd0, 1'b0);

    rmode = M_SAME;
    push_send("t5_s0", 16'h2000, 0);
    push_send("t5_s1", 16'h4004, 2);
    push_done("t5_done", 0);
    run(2);
    wait_idle("t5", 100);
    probe("t5_end", 1'b0, 1'b0, 2'd0, 3'd1, 1'b0);

    push_done("t6_zero", 1);
    run(0);
    wait_idle("t6", 20);
    probe("t6_end", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);

    rmode = M_NORMAL;
    push_send("t7_s0", 16'h2000, 0);
    push_send("t7_s1", 16'h4004, 2);
    push_done("t7_done", 0);
    run(2);
    repeat (4) @(negedge clk);
    start = 1'b1; num_cmds = 4'd1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle("t7", 100);
    push_send("t7_keep", 16'h2000, 0);
    push_done("t7_done2", 0);
    run(1);
    wait_idle("t7b", 100);

    push_send("t8_fresh", 16'hABCD, 0);
    push_done("t8_done", 0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hABCD;
    start = 1'b1; num_cmds = 4'd1; start_cyc = cyc;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_idle("t8", 100);

    rmode = M_NORESP;
    push_send("t9_s0", 16'hABCD, 0);
    run(1);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    probe("t9_abort", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    repeat (120) @(negedge clk);
    rmode = M_NORMAL;
    push_send("t9_re", 16'hABCD, 0);
    push_done("t9_done", 0);
    run(1);
    wait_idle("t9", 100);
    probe("t9_end", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);

    rmode = M_NORESP;
    push_send("t10_s0", 16'hABCD, 0);
    run(1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    probe("t10_rst", 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    repeat (120) @(negedge clk);
    rmode = M_NORMAL;
    push_send("t10_s0b", 16'hABCD, 0);
    push_send("t10_s1b", 16'h4004, 2);
    push_done("t10_done", 0);
    run(2);
    wait_idle("t10", 100);
    probe("t10_end", 1'b0, 1'b0, 2'd0, 3'd1, 1'b0);

    push_probe("final", P_EMPTY);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
